lfsr_stream_checker: RTL and testbench

- Receive-side companion to the LFSR generator top.
- Consumes the serial bit stream produced by a Fibonacci LFSR with programmable taps.
- Self-seeds from the incoming bits, then predicts every following bit and compares it with the bit received.
- Reports lock status and a saturating mismatch count. Used on-chip for loopback self-test, or off-chip as the bench/board-side checker.

---
 rtl/lfsr_stream_checker.sv | 200 ++++++++++++++++++++
 tb/tb_lfsr_stream_checker.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lfsr_stream_checker
//
// Receive-side checker for a serial stream produced by a Fibonacci LFSR with a
// programmable tap mask. The checker fills its shift register from the incoming
// bits, then predicts each following bit and compares it with the bit received.
// After LOCK_COUNT correct predictions in a row it declares lock. While locked,
// mismatches are counted in a saturating error counter. LOSS_COUNT mismatches
// in a row force a resync.
//
// Stream convention: s holds the last WIDTH bits, newest at s[0];
// predicted bit p = ^(s & taps); shift is s <= {s[WIDTH-2:0], b}.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_n_i      asynchronous active-low reset
//   bit_in_i     received stream bit
//   bit_valid_i  bit_in_i is sampled this cycle
//   taps_in_i    new tap mask
//   taps_load_i  load taps_in_i and force a resync (same-cycle bit is dropped)
//   clr_err_i    synchronous clear of err_count_o (wins over an increment)
//   locked_o     high while the FSM is in LOCKED
//   bit_err_o    one-cycle pulse: previous cycle's bit mismatched while LOCKED
//   err_count_o  saturating count of mismatches seen in LOCKED
//   fsm_state_o  debug state encoding: 00 SEED, 01 VERIFY, 10 LOCKED
// -----------------------------------------------------------------------------
module lfsr_stream_checker #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_TAPS = 8'hB8,
    parameter int unsigned      LOCK_COUNT   = 4,
    parameter int unsigned      LOSS_COUNT   = 3,
    parameter int unsigned      ERR_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             bit_in_i,
    input  logic             bit_valid_i,
    input  logic [WIDTH-1:0] taps_in_i,
    input  logic             taps_load_i,
    input  logic             clr_err_i,
    output logic             locked_o,
    output logic             bit_err_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [1:0]       fsm_state_o
);

    // Lock and loss thresholds are limited to 1..255, so 8-bit counters suffice.
    localparam int unsigned SEED_W = $clog2(WIDTH + 1);
    localparam int unsigned CNT_W  = 8;

    localparam logic [SEED_W-1:0] SEED_FULL  = SEED_W'(WIDTH);
    localparam logic [CNT_W-1:0]  LOCK_LIMIT = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  LOSS_LIMIT = CNT_W'(LOSS_COUNT);

    typedef enum logic [1:0] {
        ST_SEED   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    taps_q, taps_d;
    logic [WIDTH-1:0]    s_q, s_d;
    logic [SEED_W-1:0]   seed_cnt_q, seed_cnt_d;
    logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic                bit_err_q, bit_err_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]    tap_hits;
    logic                predicted;
    logic                mismatch;
    logic                err_inc;
    logic [SEED_W-1:0]   seed_cnt_inc;
    logic [CNT_W-1:0]    match_cnt_inc;
    logic [CNT_W-1:0]    miss_cnt_inc;

    // Per-bit AND of history and tap mask; the prediction is their parity.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap_hits
            assign tap_hits[gi] = s_q[gi] & taps_q[gi];
        end
    endgenerate

    assign predicted     = ^tap_hits;
    assign mismatch      = bit_in_i ^ predicted;
    assign seed_cnt_inc  = seed_cnt_q + SEED_W'(1);
    assign match_cnt_inc = match_cnt_q + CNT_W'(1);
    assign miss_cnt_inc  = miss_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        taps_d      = taps_q;
        s_d         = s_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        bit_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        err_inc     = 1'b0;

        if (taps_load_i) begin
            // A tap change invalidates everything learned so far; any bit
            // presented on this cycle belongs to neither configuration.
            taps_d      = taps_in_i;
            state_d     = ST_SEED;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
        end else if (bit_valid_i) begin
            unique case (state_q)
                ST_SEED: begin
                    s_d        = {s_q[WIDTH-2:0], bit_in_i};
                    seed_cnt_d = seed_cnt_inc;
                    if (seed_cnt_inc == SEED_FULL) begin
                        state_d     = ST_VERIFY;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end
                end
                ST_VERIFY: begin
                    s_d = {s_q[WIDTH-2:0], bit_in_i};
                    if (!mismatch) begin
                        match_cnt_d = match_cnt_inc;
                        if (match_cnt_inc == LOCK_LIMIT) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        // The offending bit is already in s, so it counts as
                        // the first bit of the new seed.
                        state_d    = ST_SEED;
                        seed_cnt_d = SEED_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Shift in the prediction rather than the received bit so
                    // a corrupted bit cannot derail the local copy of the LFSR.
                    s_d = {s_q[WIDTH-2:0], predicted};
                    if (mismatch) begin
                        bit_err_d  = 1'b1;
                        err_inc    = 1'b1;
                        miss_cnt_d = miss_cnt_inc;
                        if (miss_cnt_inc == LOSS_LIMIT) begin
                            state_d    = ST_SEED;
                            seed_cnt_d = '0;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: begin
                    // Unused encoding: fall back to a clean resync.
                    state_d     = ST_SEED;
                    seed_cnt_d  = '0;
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
            endcase
        end

        if (err_inc && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
        // Clear has priority over a same-cycle increment.
        if (clr_err_i) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_SEED;
            taps_q      <= DEFAULT_TAPS;
            s_q         <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            bit_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            taps_q      <= taps_d;
            s_q         <= s_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            bit_err_q   <= bit_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked_o    = (state_q == ST_LOCKED);
    assign bit_err_o   = bit_err_q;
    assign err_count_o = err_cnt_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_lfsr_stream_checker
//
// Two checkers share one stimulus stream: u_dut with default parameters and
// u_sat with a 4-bit error counter and LOSS_COUNT=255 (never loses lock), so
// saturation can be exercised alongside the normal lock/loss behaviour.
// A behavioural model (history kept as an integer array, prediction as a loop
// over tap positions) is stepped at every rising edge and compared against
// both DUTs on every falling edge. Directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_lfsr_stream_checker;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         bit_in;
    logic         bit_valid;
    logic [W-1:0] taps_in;
    logic         taps_load;
    logic         clr_err;

    logic         locked0, bit_err0;
    logic [15:0]  err0;
    logic [1:0]   fsm0;
    logic         locked1, bit_err1;
    logic [3:0]   err1;
    logic [1:0]   fsm1;

    always #5 clk = ~clk;

    lfsr_stream_checker u_dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bit_in_i    (bit_in),
        .bit_valid_i (bit_valid),
        .taps_in_i   (taps_in),
        .taps_load_i (taps_load),
        .clr_err_i   (clr_err),
        .locked_o    (locked0),
        .bit_err_o   (bit_err0),
        .err_count_o (err0),
        .fsm_state_o (fsm0)
    );

    lfsr_stream_checker #(.ERR_W(4), .LOSS_COUNT(255)) u_sat (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bit_in_i    (bit_in),
        .bit_valid_i (bit_valid),
        .taps_in_i   (taps_in),
        .taps_load_i (taps_load),
        .clr_err_i   (clr_err),
        .locked_o    (locked1),
        .bit_err_o   (bit_err1),
        .err_count_o (err1),
        .fsm_state_o (fsm1)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0: u_dut, 1: u_sat) ----------
    // m_state: 0 SEED, 1 VERIFY, 2 LOCKED. m_hist[i][k] = stream bit k back.
    int m_state[2], m_seed[2], m_match[2], m_miss[2];
    int m_err[2], m_pulse[2], m_taps[2];
    int m_hist[2][W];

    function automatic int loss_of(input int i);
        return (i == 0) ? 3 : 255;
    endfunction

    function automatic int errmax_of(input int i);
        return (i == 0) ? 65535 : 15;
    endfunction

    function automatic int predict(input int i);
        int p = 0;
        for (int k = 0; k < W; k++)
            if (((m_taps[i] >> k) & 1) == 1) p = p ^ m_hist[i][k];
        return p;
    endfunction

    task automatic push(input int i, input int b);
        for (int k = W - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = b;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_seed[i] = 0; m_match[i] = 0; m_miss[i] = 0;
            m_err[i] = 0; m_pulse[i] = 0; m_taps[i] = 'hB8;
            for (int k = 0; k < W; k++) m_hist[i][k] = 0;
        end
    endtask

    task automatic model_step(input int b, input int v, input int ld, input int tin, input int clr);
        for (int i = 0; i < 2; i++) begin
            int p;
            m_pulse[i] = 0;
            if (ld != 0) begin
                m_taps[i] = tin; m_state[i] = 0;
                m_seed[i] = 0; m_match[i] = 0; m_miss[i] = 0;
            end else if (v != 0) begin
                p = predict(i);
                if (m_state[i] == 0) begin
                    push(i, b);
                    m_seed[i]++;
                    if (m_seed[i] == W) begin m_state[i] = 1; m_match[i] = 0; end
                end else if (m_state[i] == 1) begin
                    push(i, b);
                    if (b == p) begin
                        m_match[i]++;
                        if (m_match[i] == 4) begin m_state[i] = 2; m_miss[i] = 0; end
                    end else begin
                        m_state[i] = 0; m_seed[i] = 1;
                    end
                end else begin
                    push(i, p);
                    if (b != p) begin
                        m_pulse[i] = 1;
                        if (m_err[i] < errmax_of(i)) m_err[i]++;
                        m_miss[i]++;
                        if (m_miss[i] == loss_of(i)) begin
                            m_state[i] = 0; m_seed[i] = 0; m_miss[i] = 0;
                        end
                    end else begin
                        m_miss[i] = 0;
                    end
                end
            end
            if (clr != 0) m_err[i] = 0;
        end
    endtask

    // ---------------- per-cycle comparison -----------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("locked0",  int'(locked0),  int'(m_state[0] == 2));
            check("bit_err0", int'(bit_err0), m_pulse[0]);
            check("err0",     int'(err0),     m_err[0]);
            check("fsm0",     int'(fsm0),     m_state[0]);
            check("locked1",  int'(locked1),  int'(m_state[1] == 2));
            check("bit_err1", int'(bit_err1), m_pulse[1]);
            check("err1",     int'(err1),     m_err[1]);
            check("fsm1",     int'(fsm1),     m_state[1]);
        end
    end

    // ---------------- stimulus -----------------------------------------------
    logic [W-1:0] g;   // reference generator history (same convention as DUT)
    logic [W-1:0] gt;  // reference generator taps

    // One clock of stimulus; returns #1 after the rising edge.
    task automatic cyc(input int b, input int v, input int ld, input int tin, input int clr);
        bit_in    = b[0];
        bit_valid = v[0];
        taps_load = ld[0];
        taps_in   = tin[W-1:0];
        clr_err   = clr[0];
        @(posedge clk);
        model_step(b & 1, v, ld, tin, clr);
        #1;
        $display("t=%0t in=%0d v=%0d ld=%0d clr=%0d | dut: lk=%0d be=%0d err=%0d st=%0d | sat: lk=%0d be=%0d err=%0d st=%0d",
                 $time, b & 1, v, ld, clr, locked0, bit_err0, err0, fsm0,
                 locked1, bit_err1, err1, fsm1);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0);
    endtask

    // Send the next generator bit. inv flips it on the wire; absorb makes the
    // generator continue from the bit actually sent (a consistent new stream).
    task automatic send(input int inv, input int clr, input int absorb);
        logic b, tx;
        b  = ^(g & gt);
        tx = b ^ inv[0];
        g  = {g[W-2:0], (absorb != 0) ? tx : b};
        cyc(int'(tx), 1, 0, 0, clr);
    endtask

    task automatic send_n(input int n);
        for (int k = 0; k < n; k++) send(0, 0, 0);
    endtask

    initial begin
        logic [11:0] first12;
        int          saved_err;

        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        taps_in = '0; taps_load = 1'b0; clr_err = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("reset_locked", int'(locked0), 0);
        check("reset_biterr", int'(bit_err0), 0);
        check("reset_err",    int'(err0), 0);
        check("reset_fsm",    int'(fsm0), 0);
        idle();

        // Pin the reference generator: from 0x01 with taps 0xB8 the first
        // twelve bits are 0001_1100_0100.
        g = 8'h01; gt = 8'hB8;
        first12 = '0;
        for (int k = 0; k < 12; k++) begin
            first12 = {first12[10:0], ^(g & gt)};
            g = {g[W-2:0], ^(g & gt)};
        end
        check("gen_pin", int'(first12), 12'h1C4);

        // ---- Lock with default taps ----
        g = 8'h01; gt = 8'hB8;
        send_n(8);
        check("lock_after_seed_fsm", int'(fsm0), 1);
        send_n(3);
        check("lock_bit11_locked", int'(locked0), 0);
        send_n(1);
        check("lock_bit12_locked", int'(locked0), 1);
        check("lock_fsm", int'(fsm0), 2);
        check("lock_err", int'(err0), 0);

        // ---- Single error ----
        send_n(4);
        send(1, 0, 0);
        check("single_biterr", int'(bit_err0), 1);
        check("single_err", int'(err0), 1);
        check("single_locked", int'(locked0), 1);
        send_n(1);
        check("single_biterr_clear", int'(bit_err0), 0);
        send_n(5);
        check("single_err_hold", int'(err0), 1);
        check("single_still_locked", int'(locked0), 1);

        // ---- Loss of lock ----
        cyc(0, 0, 0, 0, 1);
        check("clr_alone", int'(err0), 0);
        send(1, 0, 0);
        send(1, 0, 0);
        check("loss_2nd_locked", int'(locked0), 1);
        send(1, 0, 0);
        check("loss_locked", int'(locked0), 0);
        check("loss_fsm", int'(fsm0), 0);
        check("loss_err", int'(err0), 3);
        check("nosat_locked", int'(locked1), 1);
        send_n(11);
        check("relock_11", int'(locked0), 0);
        send_n(1);
        check("relock_12", int'(locked0), 1);
        check("relock_err", int'(err0), 3);

        // ---- Verify failure on bit 10 ----
        cyc(0, 0, 1, 'hB8, 0);
        check("load_unlocks", int'(locked0), 0);
        g = 8'h01; gt = 8'hB8;
        send_n(9);
        send(1, 0, 1);
        check("vfail_fsm", int'(fsm0), 0);
        check("vfail_err", int'(err0), 3);
        send_n(6);
        check("vfail_seed6_fsm", int'(fsm0), 0);
        send_n(1);
        check("vfail_seed7_fsm", int'(fsm0), 1);
        send_n(3);
        check("vfail_v3_locked", int'(locked0), 0);
        send_n(1);
        check("vfail_relock", int'(locked0), 1);

        // ---- Saturation and clear (u_sat) ----
        cyc(0, 0, 1, 'hB8, 0);
        g = 8'h01; gt = 8'hB8;
        send_n(12);
        check("sat_locked", int'(locked1), 1);
        for (int k = 0; k < 20; k++) send(1, 0, 0);
        check("sat_err", int'(err1), 15);
        check("sat_still_locked", int'(locked1), 1);
        send(1, 1, 0);
        check("sat_clr_wins", int'(err1), 0);
        check("sat_clr_biterr", int'(bit_err1), 1);

        // ---- taps_load while locked ----
        cyc(0, 0, 1, 'hB8, 0);
        g = 8'h01; gt = 8'hB8;
        send_n(12);
        check("tl_locked", int'(locked0), 1);
        saved_err = m_err[0];
        cyc(1, 1, 1, 'h8E, 0);
        check("tl_unlock", int'(locked0), 0);
        check("tl_fsm", int'(fsm0), 0);
        check("tl_err_kept", int'(err0), saved_err);
        g = 8'h01; gt = 8'h8E;
        send_n(8);
        check("tl_seed_done_fsm", int'(fsm0), 1);
        send_n(3);
        check("tl_11_locked", int'(locked0), 0);
        send_n(1);
        check("tl_12_locked", int'(locked0), 1);

        // ---- Asynchronous reset mid-stream ----
        send_n(3);
        bit_valid = 1'b0; taps_load = 1'b0; clr_err = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_locked0", int'(locked0), 0);
        check("arst_biterr0", int'(bit_err0), 0);
        check("arst_err0",    int'(err0), 0);
        check("arst_fsm0",    int'(fsm0), 0);
        check("arst_locked1", int'(locked1), 0);
        check("arst_err1",    int'(err1), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        // Taps must be back to 0xB8.
        g = 8'h01; gt = 8'hB8;
        send_n(11);
        check("arst_11_locked", int'(locked0), 0);
        send_n(1);
        check("arst_relock", int'(locked0), 1);
        idle();
        idle();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
